// File: rtl/credit_tx_pkg.sv
// Shared types and helpers for the credit-based transmit channel.
// The receiver-side credit return logic imports the same width helper so
// both ends size their credit counters identically.
package credit_tx_pkg;

   // Transmitter control states. The encoding is visible on dbg_state.
   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } credit_tx_state_t;

   localparam int CREDIT_TX_DW_DEFAULT      = 16;
   localparam int CREDIT_TX_CREDITS_DEFAULT = 4;

   // Width of a counter that must hold every value 0..slots inclusive.
   function automatic int credit_cnt_width(input int slots);
      return $clog2(slots + 1);
   endfunction

endpackage

// File: rtl/credit_tx.sv
// Transmitter end of a credit-based point-to-point link.
// Accepts words on a valid/ready port and pushes them, one register later,
// into a remote receive buffer of CREDITS slots. One credit is spent per push
// and one comes back per remote pop, so the remote buffer is never overfilled.
//
// Handshake: a word moves upstream->here on a rising edge where
// in_valid & in_ready are both high. in_ready depends only on registered
// state (never on in_valid), so the producer may hold in_valid and in_data
// steady until the transfer happens. Downstream has no ready: out_valid is
// a one-cycle push strobe carrying out_data.
module credit_tx
   import credit_tx_pkg::*;
#(
   parameter int  DW        = CREDIT_TX_DW_DEFAULT,
   parameter int  CREDITS   = CREDIT_TX_CREDITS_DEFAULT,
   parameter bit  OVF_FATAL = 1'b1,
   localparam int CW        = credit_cnt_width(CREDITS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DW-1:0]    in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [DW-1:0]    out_data,
   output logic             out_valid,
   input  logic             credit_in,
   output logic [CW-1:0]    credits,
   output logic             err_overflow,
   output credit_tx_state_t dbg_state
);

   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
   localparam logic [CW-1:0] CRED_ONE = CW'(1);

   // A receive buffer with no slots can never accept a word.
   if (CREDITS < 1) begin : g_bad_credits
      $error("credit_tx: CREDITS must be at least 1");
   end

   credit_tx_state_t r_state;
   logic [CW-1:0]    r_credits;
   logic             r_out_valid;
   logic             r_err;
   logic [DW-1:0]    r_out_data;

   logic             w_in_ready;
   logic             w_xfer;
   logic             w_full;
   logic             w_ovf;

   // Ready only while running and holding at least one credit.
   assign w_in_ready = (r_state == RUN) && (r_credits != '0);
   assign w_xfer     = in_valid & w_in_ready;
   assign w_full     = (r_credits == CRED_MAX);
   // A credit with the counter already full and nothing spent this cycle
   // means the receiver popped more than was ever pushed.
   assign w_ovf      = credit_in & ~w_xfer & w_full;

   // Up/down credit counter; saturates at CREDITS on an overflowing return.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_credits <= CRED_MAX;
      end else begin
         if (w_xfer && !credit_in) begin
            r_credits <= r_credits - CRED_ONE;
         end else if (!w_xfer && credit_in && !w_full) begin
            r_credits <= r_credits + CRED_ONE;
         end
      end
   end

   // Control FSM with its registered push strobe and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= INIT;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_out_valid <= w_xfer;
         if (w_ovf) begin
            r_err <= 1'b1;
         end
         case (r_state)
            INIT: r_state <= w_ovf ? ERR : RUN;
            RUN:  r_state <= w_ovf ? ERR : RUN;
            ERR:  r_state <= ERR;
            default: r_state <= ERR;
         endcase
      end
   end

   // Data register; left unreset since out_valid qualifies it.
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_out_data <= in_data;
      end
   end

   // Stop simulation when the receiver returns a credit it never owed.
   always_ff @(posedge clk) begin
      if (OVF_FATAL && rst_n) begin
         assert (!w_ovf)
         else $fatal(1, "credit_tx: credit returned with counter already at CREDITS");
      end
   end

   assign in_ready     = w_in_ready;
   assign out_data     = r_out_data;
   assign out_valid    = r_out_valid;
   assign credits      = r_credits;
   assign err_overflow = r_err;
   assign dbg_state    = r_state;

endmodule
